// File: rtl/pll_lock_supervisor.sv
// Purpose : PLL lock supervisor - pulses the PLL reset, qualifies lock_s over
//           STABLE_CYCLES, then releases downstream reset and tracks lock losses.
// Latency : locked rises STABLE_CYCLES+3 edges after pll_lock is first sampled high;
//           lock loss clears locked/sys_rst_n 3 edges after pll_lock falls.
// Backpressure: none; free-running status block, clr_err is a single-cycle pulse.
//
// Ports:
//   clk          supervisor clock (independent of the PLL)
//   rst_n        asynchronous active-low reset
//   pll_lock     raw PLL lock, asynchronous to clk (2-flop synchronised)
//   clr_err      pulse: clears err and loss_cnt on the next edge
//   pll_rst      active-high PLL reset request (high only in RST)
//   sys_rst_n    active-low downstream reset (released only in RUN)
//   locked       qualified lock status (high only in RUN)
//   err          sticky lock-loss flag
//   loss_cnt     saturating lock-loss counter
//   timeout_cnt  saturating lock-wait timeout counter
//   state        FSM code: RST=0 WAIT=1 STABLE=2 RUN=3 LOST=4
//
// Build option: define PLL_SUP_LOSS_RESET_EN to re-reset the PLL after a lock
// loss (LOST -> RST). Default build goes LOST -> WAIT without a pll_rst pulse.

module pll_lock_supervisor #(
    parameter int RST_PULSE      = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       clr_err,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       locked,
    output logic       err,
    output logic [7:0] loss_cnt,
    output logic [3:0] timeout_cnt,
    output logic [2:0] state
);

    // One shared dwell counter; sized for the longest of the three intervals.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > STABLE_CYCLES)
                           ? ((TIMEOUT_CYCLES > RST_PULSE) ? TIMEOUT_CYCLES : RST_PULSE)
                           : ((STABLE_CYCLES  > RST_PULSE) ? STABLE_CYCLES  : RST_PULSE);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_LOST   = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sync1_q;
    logic             lock_s_q;
    logic             pll_rst_q;
    logic             sys_rst_n_q;
    logic             locked_q;
    logic             err_q;
    logic [7:0]       loss_cnt_q;
    logic [3:0]       timeout_cnt_q;

    logic             loss_evt;
    logic             err_d;
    logic [7:0]       loss_cnt_d;
    logic [3:0]       timeout_cnt_inc;

    // Lock loss is only recognised while running.
    assign loss_evt = (state_q == ST_RUN) && !lock_s_q;

    // Error bookkeeping: a loss on the same edge as clr_err wins, leaving a
    // fresh count of one rather than zero.
    always_comb begin
        err_d      = err_q;
        loss_cnt_d = loss_cnt_q;
        if (loss_evt) begin
            err_d = 1'b1;
            if (clr_err)
                loss_cnt_d = 8'd1;
            else if (loss_cnt_q != 8'hFF)
                loss_cnt_d = loss_cnt_q + 8'd1;
        end else if (clr_err) begin
            err_d      = 1'b0;
            loss_cnt_d = 8'd0;
        end
    end

    assign timeout_cnt_inc = (timeout_cnt_q == 4'hF) ? 4'hF : timeout_cnt_q + 4'd1;

    // Two-flop synchroniser for the asynchronous lock input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_lock;
            lock_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            loss_cnt_q <= 8'd0;
        end else begin
            err_q      <= err_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    // Main FSM; pll_rst/locked/sys_rst_n are registered and change on the
    // same edge as the state transition that implies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RST;
            cnt_q         <= '0;
            pll_rst_q     <= 1'b1;
            sys_rst_n_q   <= 1'b0;
            locked_q      <= 1'b0;
            timeout_cnt_q <= 4'd0;
        end else begin
            case (state_q)
                ST_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_q   <= ST_WAIT;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (lock_s_q) begin
                        state_q <= ST_STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q       <= ST_RST;
                        cnt_q         <= '0;
                        pll_rst_q     <= 1'b1;
                        timeout_cnt_q <= timeout_cnt_inc;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STABLE: begin
                    // Any low sample (including a short glitch) restarts qualification.
                    if (!lock_s_q) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q     <= ST_RUN;
                        cnt_q       <= '0;
                        locked_q    <= 1'b1;
                        sys_rst_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s_q) begin
                        state_q     <= ST_LOST;
                        cnt_q       <= '0;
                        locked_q    <= 1'b0;
                        sys_rst_n_q <= 1'b0;
                    end
                end
                ST_LOST: begin
                    cnt_q <= '0;
`ifdef PLL_SUP_LOSS_RESET_EN
                    state_q   <= ST_RST;
                    pll_rst_q <= 1'b1;
`else
                    state_q   <= ST_WAIT;
`endif
                end
                default: begin
                    state_q     <= ST_RST;
                    cnt_q       <= '0;
                    pll_rst_q   <= 1'b1;
                    sys_rst_n_q <= 1'b0;
                    locked_q    <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst_n   = sys_rst_n_q;
    assign locked      = locked_q;
    assign err         = err_q;
    assign loss_cnt    = loss_cnt_q;
    assign timeout_cnt = timeout_cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Purpose : scoreboard bench for pll_lock_supervisor with a timestamp-based
//           reference model (RST_PULSE=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32).
// Latency : driver pushes expected outputs at negedge, monitor checks 1 ns after posedge.
// Backpressure: none.

module tb_pll_lock_supervisor;

    localparam int RP = 4;
    localparam int SC = 8;
    localparam int TO = 32;

    localparam int M_RST = 0, M_WAIT = 1, M_STABLE = 2, M_RUN = 3, M_LOST = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       clr_err;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       locked;
    logic       err;
    logic [7:0] loss_cnt;
    logic [3:0] timeout_cnt;
    logic [2:0] state;

    typedef struct packed {
        logic       pll_rst;
        logic       sys_rst_n;
        logic       locked;
        logic       err;
        logic [7:0] loss;
        logic [3:0] tmo;
        logic [2:0] st;
    } obs_t;

    obs_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // reference model state: current mode, edge at which it was entered,
    // and the raw samples still travelling through the synchroniser
    int   m_mode  = M_RST;
    int   m_entry = 0;
    int   m_edge  = 0;
    bit   m_samp[$];
    bit   m_err   = 1'b0;
    int   m_loss  = 0;
    int   m_tmo   = 0;
    bit   prev_rst = 1'b0;

    pll_lock_supervisor #(
        .RST_PULSE     (RP),
        .STABLE_CYCLES (SC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .clr_err    (clr_err),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .locked     (locked),
        .err        (err),
        .loss_cnt   (loss_cnt),
        .timeout_cnt(timeout_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    function automatic obs_t dut_obs();
        obs_t o;
        o.pll_rst   = pll_rst;
        o.sys_rst_n = sys_rst_n;
        o.locked    = locked;
        o.err       = err;
        o.loss      = loss_cnt;
        o.tmo       = timeout_cnt;
        o.st        = state;
        return o;
    endfunction

    // Outputs follow from the mode alone: pll_rst only in RST, locked and
    // sys_rst_n only in RUN.
    function automatic obs_t model_obs();
        obs_t o;
        o.pll_rst   = (m_mode == M_RST);
        o.sys_rst_n = (m_mode == M_RUN);
        o.locked    = (m_mode == M_RUN);
        o.err       = m_err;
        o.loss      = 8'(m_loss);
        o.tmo       = 4'(m_tmo);
        o.st        = 3'(m_mode);
        return o;
    endfunction

    function automatic obs_t reset_obs();
        obs_t o;
        o.pll_rst   = 1'b1;
        o.sys_rst_n = 1'b0;
        o.locked    = 1'b0;
        o.err       = 1'b0;
        o.loss      = 8'd0;
        o.tmo       = 4'd0;
        o.st        = 3'd0;
        return o;
    endfunction

    task automatic check(input obs_t got, input obs_t exp, input string tag);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got pll_rst=%0b sys_rst_n=%0b locked=%0b err=%0b loss=%0d tmo=%0d st=%0d, required pll_rst=%0b sys_rst_n=%0b locked=%0b err=%0b loss=%0d tmo=%0d st=%0d",
                     tag, $time, got.pll_rst, got.sys_rst_n, got.locked, got.err, got.loss, got.tmo, got.st,
                     exp.pll_rst, exp.sys_rst_n, exp.locked, exp.err, exp.loss, exp.tmo, exp.st);
        end
    endtask

    // One clock edge of the behavioural model.
    task automatic model_edge(input bit r, input bit p, input bit c);
        bit ls;
        int dwell;
        int nxt;
        bit lost;
        m_edge++;
        if (!r) begin
            m_mode  = M_RST;
            m_entry = m_edge + 1;
            m_samp.delete();
            m_samp.push_back(1'b0);
            m_samp.push_back(1'b0);
            m_err  = 1'b0;
            m_loss = 0;
            m_tmo  = 0;
            return;
        end
        ls = m_samp.pop_front();   // value seen two edges ago
        m_samp.push_back(p);
        dwell = m_edge - m_entry;  // edges already spent in the mode
        nxt   = m_mode;
        lost  = 1'b0;
        case (m_mode)
            M_RST:    if (dwell == RP - 1) nxt = M_WAIT;
            M_WAIT: begin
                if (ls) nxt = M_STABLE;
                else if (dwell == TO - 1) begin
                    nxt   = M_RST;
                    m_tmo = (m_tmo < 15) ? m_tmo + 1 : 15;
                end
            end
            M_STABLE: begin
                if (!ls) nxt = M_WAIT;
                else if (dwell == SC - 1) nxt = M_RUN;
            end
            M_RUN: if (!ls) begin nxt = M_LOST; lost = 1'b1; end
            default: begin
`ifdef PLL_SUP_LOSS_RESET_EN
                nxt = M_RST;
`else
                nxt = M_WAIT;
`endif
            end
        endcase
        if (nxt != m_mode) begin
            m_mode  = nxt;
            m_entry = m_edge + 1;
        end
        if (lost) begin
            m_err  = 1'b1;
            m_loss = c ? 1 : ((m_loss < 255) ? m_loss + 1 : 255);
        end else if (c) begin
            m_err  = 1'b0;
            m_loss = 0;
        end
    endtask

    // Called at a negedge: apply inputs for the coming posedge, queue the
    // predicted outputs, return at the next negedge.
    task automatic drive(input bit r, input bit p, input bit c);
        rst_n    = r;
        pll_lock = p;
        clr_err  = c;
        if (prev_rst && !r) begin
            #1;
            check(dut_obs(), reset_obs(), "async_reset");
        end
        prev_rst = r;
        model_edge(r, p, c);
        sb.push_back(model_obs());
        @(negedge clk);
    endtask

    // Monitor
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(dut_obs(), e, "edge");
            end
        end
    end

    // Stimulus
    initial begin
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        clr_err  = 1'b0;
        m_samp.push_back(1'b0);
        m_samp.push_back(1'b0);
        @(negedge clk);

        // reset, then long lock-low stretch: repeated timeouts to saturation
        repeat (3)   drive(1'b0, 1'b0, 1'b0);
        repeat (700) drive(1'b1, 1'b0, 1'b0);

        // clean lock, then a one-cycle glitch during qualification
        repeat (20) drive(1'b1, 1'b1, 1'b0);
        repeat (3)  drive(1'b1, 1'b0, 1'b0);
        repeat (7)  drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        repeat (20) drive(1'b1, 1'b1, 1'b0);

        // loss coinciding with clr_err, then a lone clr_err
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        repeat (6) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 1'b0);

        // randomised segments
        for (int k = 0; k < 400; k++) begin
            int kind;
            int len;
            bit lvl;
            kind = $urandom_range(0, 3);
            lvl  = (kind == 0);
            case (kind)
                0:       len = $urandom_range(1, 24);
                1:       len = $urandom_range(1, 4);
                2:       len = $urandom_range(30, 40);
                default: len = 6;
            endcase
            for (int j = 0; j < len; j++) begin
                bit r;
                bit p;
                r = ($urandom_range(0, 299) != 0);
                p = (kind == 3) ? 1'($urandom_range(0, 1)) : lvl;
                drive(r, p, ($urandom_range(0, 15) == 0));
            end
        end

        // more than 255 losses without clearing: loss_cnt must saturate
        for (int k = 0; k < 300; k++) begin
            repeat (18) drive(1'b1, 1'b1, 1'b0);
            repeat (2)  drive(1'b1, 1'b0, 1'b0);
        end

        // reach RUN, then pulse reset while running
        repeat (20) drive(1'b1, 1'b1, 1'b0);
        repeat (2)  drive(1'b0, 1'b1, 1'b0);
        repeat (20) drive(1'b1, 1'b1, 1'b0);

        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d unchecked entries, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
